// File: rtl/router_pkt_src_if.sv
// Handshake and byte-bus bundle between the packet source, its upstream
// feeder and the router input port.
interface router_pkt_src_if;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       done;
  logic       err;

  // Driver side: requests packets, feeds payload, applies router backpressure.
  modport master (
    output start, dest_addr, payload_len, src_data, src_valid, busy,
    input  src_ready, data_out, pkt_valid, done, err
  );

  // Packet source side.
  modport slave (
    input  start, dest_addr, payload_len, src_data, src_valid, busy,
    output src_ready, data_out, pkt_valid, done, err
  );
endinterface

// File: rtl/router_pkt_src.sv
// Router packet source: buffers an upstream payload, then emits
// header / payload / parity onto the router input with busy backpressure.
module router_pkt_src #(
  parameter int unsigned BUF_DEPTH    = 64,
  parameter logic [1:0]  ADDR_ILLEGAL = 2'b11
) (
  input  logic           clk,
  input  logic           resetn,
  router_pkt_src_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY} state_t;

  state_t     state_q, state_d;
  logic [7:0] header_q, header_d;   // {len, addr}; len is header_q[7:2]
  logic [7:0] parity_q, parity_d;
  logic [5:0] cnt_q, cnt_d;         // write count in LOAD, read index in PAYLOAD
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       buf_we;
  logic [7:0] buf_mem [BUF_DEPTH];

  assign bus.src_ready = (state_q == LOAD);
  assign bus.data_out  = data_q;
  assign bus.pkt_valid = valid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  // Next-state and next-output logic; data_out/pkt_valid are computed one
  // cycle ahead so they leave the block straight from flops.
  always_comb begin
    state_d  = state_q;
    header_d = header_q;
    parity_d = parity_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    buf_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.payload_len == '0 || bus.dest_addr == ADDR_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            header_d = {bus.payload_len, bus.dest_addr};
            parity_d = {bus.payload_len, bus.dest_addr};
            cnt_d    = '0;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        if (bus.src_valid) begin
          buf_we   = 1'b1;
          parity_d = parity_q ^ bus.src_data;
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == header_q[7:2] - 6'd1) begin
            state_d = HEADER;
            data_d  = header_q;
            valid_d = 1'b1;
          end
        end
      end
      HEADER: begin
        if (!bus.busy) begin
          state_d = PAYLOAD;
          cnt_d   = '0;
          data_d  = buf_mem[0];
        end
      end
      PAYLOAD: begin
        if (!bus.busy) begin
          if (cnt_q == header_q[7:2] - 6'd1) begin
            state_d = PARITY;
            data_d  = parity_q;
            valid_d = 1'b0;
          end else begin
            cnt_d  = cnt_q + 6'd1;
            data_d = buf_mem[cnt_q + 6'd1];
          end
        end
      end
      PARITY: begin
        if (!bus.busy) begin
          state_d = IDLE;
          data_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      header_q <= '0;
      parity_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      header_q <= header_d;
      parity_q <= parity_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Payload storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[cnt_q] <= bus.src_data;
  end

endmodule

// File: tb/tb_router_pkt_src.sv
// Self-checking bench for router_pkt_src: a packet-level reference model
// (expected byte sequence + transmit pointer) checked on every cycle,
// plus directed literal checks for the documented scenarios.
module tb_router_pkt_src;
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  router_pkt_src_if bus ();

  router_pkt_src #(.BUF_DEPTH(64), .ADDR_ILLEGAL(2'b11)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 collecting payload, 2 sending m_seq
  int         m_phase;
  int         m_len;
  int         m_ptr;
  logic [7:0] m_seq[$];
  logic [7:0] exp_data;
  logic       exp_valid, exp_ready, exp_done, exp_err;

  function automatic void m_clear();
    m_phase = 0; m_len = 0; m_ptr = 0; m_seq.delete();
    exp_data = '0; exp_valid = 0; exp_ready = 0; exp_done = 0; exp_err = 0;
  endfunction

  function automatic void m_step();
    logic [7:0] par;
    exp_done = 0;
    exp_err  = 0;
    case (m_phase)
      0: if (bus.start) begin
        if (bus.payload_len == 0 || bus.dest_addr == 2'b11) exp_err = 1;
        else begin
          m_len = int'(bus.payload_len);
          m_seq.delete();
          m_seq.push_back({bus.payload_len, bus.dest_addr});
          m_phase = 1;
        end
      end
      1: if (bus.src_valid) begin
        m_seq.push_back(bus.src_data);
        if (m_seq.size() == m_len + 1) begin
          par = '0;
          foreach (m_seq[i]) par ^= m_seq[i];
          m_seq.push_back(par);
          m_phase = 2;
          m_ptr   = 0;
        end
      end
      default: if (!bus.busy) begin
        m_ptr++;
        if (m_ptr == m_len + 2) begin
          m_phase  = 0;
          exp_done = 1;
        end
      end
    endcase
    exp_ready = (m_phase == 1);
    if (m_phase == 2) begin
      exp_data  = m_seq[m_ptr];
      exp_valid = (m_ptr <= m_len);
    end else begin
      exp_data  = '0;
      exp_valid = 0;
    end
  endfunction

  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) m_clear();
      else         m_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("data_out",  bus.data_out,  exp_data);
    chk("pkt_valid", bus.pkt_valid, exp_valid);
    chk("src_ready", bus.src_ready, exp_ready);
    chk("done",      bus.done,      exp_done);
    chk("err",       bus.err,       exp_err);
  end

  // ---------------- stimulus helpers (enter and leave on a negedge) ----------------
  logic [7:0] bytes[$];
  int         hold04;

  task automatic pulse_start(input logic [5:0] len, input logic [1:0] addr);
    bus.start = 1; bus.payload_len = len; bus.dest_addr = addr;
    @(negedge clk);
    bus.start = 0;
  endtask

  task automatic feed(input logic [7:0] b[$], input int gap_mode, input bit junk);
    int i   = 0;
    int cyc = 0;
    logic v, rdy;
    bit complete;
    while (i < b.size() && cyc < 1000) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.src_valid = v;
      bus.src_data  = v ? b[i] : 8'($urandom);
      if (junk) begin
        bus.start       = ($urandom_range(0, 3) == 0);
        bus.payload_len = 6'($urandom);
        bus.dest_addr   = 2'($urandom);
      end
      rdy = bus.src_ready;
      @(negedge clk);
      if (v && rdy) i++;
      cyc++;
    end
    bus.src_valid = 0;
    bus.start     = 0;
    complete = (i == b.size());
    chk("feed_complete", complete, 1);
  endtask

  task automatic wait_done(input int busy_mode, input bit junk, output int h04);
    int cyc    = 0;
    int stalls = 0;
    bit seen   = 0;
    h04 = 0;
    while (!seen && cyc < 2000) begin
      if (bus.done) seen = 1;
      else begin
        if (bus.pkt_valid && bus.data_out == 8'h04) h04++;
        case (busy_mode)
          0: bus.busy = 0;
          1: bus.busy = ($urandom_range(0, 2) == 0);
          default: begin
            bus.busy = (bus.pkt_valid && bus.data_out == 8'h04 && stalls < 3);
            if (bus.busy) stalls++;
          end
        endcase
        if (junk) begin
          bus.src_valid   = $urandom_range(0, 1) == 1;
          bus.src_data    = 8'($urandom);
          bus.start       = ($urandom_range(0, 3) == 0);
          bus.payload_len = 6'($urandom);
          bus.dest_addr   = 2'($urandom);
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.busy = 0; bus.start = 0; bus.src_valid = 0;
    chk("done_seen", seen, 1);
  endtask

  task automatic rand_bytes(input int n);
    bytes.delete();
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] basic_exp [10];

  initial begin
    bus.start = 0; bus.dest_addr = '0; bus.payload_len = '0;
    bus.src_data = '0; bus.src_valid = 0; bus.busy = 0;
    basic_exp = '{8'h21, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h29};
    repeat (3) @(negedge clk);
    chk("reset_data_out", bus.data_out, 0);
    chk("reset_pkt_valid", bus.pkt_valid, 0);
    resetn = 1;
    @(negedge clk);

    // Basic packet with literal expectations.
    bytes.delete();
    for (int i = 1; i <= 8; i++) bytes.push_back(8'(i));
    pulse_start(6'd8, 2'b01);
    chk("basic_ready", bus.src_ready, 1);
    feed(bytes, 0, 0);
    for (int k = 0; k < 10; k++) begin
      chk("basic_byte", bus.data_out, basic_exp[k]);
      chk("basic_valid", bus.pkt_valid, (k < 9) ? 1 : 0);
      @(negedge clk);
    end
    chk("basic_done", bus.done, 1);

    // Busy stall on byte 04.
    pulse_start(6'd8, 2'b01);
    feed(bytes, 0, 0);
    wait_done(2, 0, hold04);
    chk("stall_hold04", hold04, 4);

    // Illegal requests.
    pulse_start(6'd0, 2'b01);
    chk("err_len0", bus.err, 1);
    chk("err_len0_ready", bus.src_ready, 0);
    @(negedge clk);
    chk("err_len0_clear", bus.err, 0);
    pulse_start(6'd5, 2'b11);
    chk("err_addr3", bus.err, 1);
    chk("err_addr3_valid", bus.pkt_valid, 0);
    repeat (3) @(negedge clk);
    chk("err_addr3_idle", bus.src_ready, 0);

    // Maximum length with upstream gaps.
    bytes.delete();
    for (int i = 0; i < 63; i++) bytes.push_back(8'(i * 7 + 3));
    pulse_start(6'd63, 2'b10);
    feed(bytes, 1, 0);
    chk("max_header", bus.data_out, 8'hFE);
    wait_done(0, 0, hold04);

    // Reset during payload byte 3.
    rand_bytes(5);
    pulse_start(6'd5, 2'b01);
    feed(bytes, 0, 0);
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", bus.pkt_valid, 1);
    #2 resetn = 0;
    #1;
    chk("async_rst_data", bus.data_out, 0);
    chk("async_rst_valid", bus.pkt_valid, 0);
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    rand_bytes(2);
    pulse_start(6'd2, 2'b00);
    feed(bytes, 0, 0);
    wait_done(0, 0, hold04);

    // Back-to-back: new start in the done cycle, junk starts mid-packet.
    rand_bytes(4);
    pulse_start(6'd4, 2'b01);
    feed(bytes, 2, 1);
    wait_done(1, 1, hold04);
    rand_bytes(3);
    pulse_start(6'd3, 2'b10);
    chk("b2b_ready", bus.src_ready, 1);
    feed(bytes, 2, 1);
    wait_done(1, 1, hold04);

    // Randomized packets with gaps, backpressure and stray starts.
    for (int p = 0; p < 20; p++) begin
      int len;
      len = $urandom_range(1, 63);
      if ($urandom_range(0, 3) == 0) pulse_start(6'($urandom_range(0, 1) * len), 2'b11);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rand_bytes(len);
      pulse_start(6'(len), 2'($urandom_range(0, 2)));
      feed(bytes, 2, 1);
      wait_done(1, 1, hold04);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
